// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the instruction-memory loader
// and other pipeline control blocks.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } loader_state_t;

    localparam int WORD_BYTES  = 4;
    localparam int PIPE_STAGES = 5;

endpackage

// File: rtl/loader_flush_timer.sv
// Loadable down-counter with a zero flag; parks at zero until reloaded.
module loader_flush_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/imem_loader.sv
// Streams instruction words into instruction memory while holding the CPU,
// then flushes the pipeline and releases it from BASE_ADDR.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int          DEPTH        = 64,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = PIPE_STAGES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [31:0]              s_data,
    input  logic                     s_last,
    output logic                     imem_we,
    output logic [31:0]              imem_addr,
    output logic [31:0]              imem_wdata,
    output logic                     cpu_hold,
    output logic                     pc_reset,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   word_count,
    output logic                     err_overflow
);

    localparam int WC_W    = $clog2(DEPTH) + 1;
    localparam int TIMER_W = $clog2(FLUSH_CYCLES) + 1;

    loader_state_t r_state;
    loader_state_t w_next_state;

    logic            r_imem_we;
    logic [31:0]     r_imem_addr;
    logic [31:0]     r_imem_wdata;
    logic [WC_W-1:0] r_word_count;
    logic            r_err_overflow;
    logic            r_done;

    logic            w_beat;
    logic [WC_W-1:0] w_wc_next;
    logic            w_full;
    logic            w_end_load;
    logic            w_start_load;
    logic            w_timer_zero;
    logic [TIMER_W-1:0] w_timer_count;

    assign w_beat       = s_valid && (r_state == LOAD);
    assign w_wc_next    = r_word_count + 1'b1;
    assign w_full       = (w_wc_next == WC_W'(DEPTH));
    assign w_end_load   = w_beat && (s_last || w_full);
    assign w_start_load = start && ((r_state == IDLE) || (r_state == RUN));

    // Timer is armed on the closing beat so FLUSH lasts exactly FLUSH_CYCLES.
    loader_flush_timer #(
        .WIDTH(TIMER_W)
    ) u_flush_timer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_end_load),
        .i_load_value(TIMER_W'(FLUSH_CYCLES - 1)),
        .i_enable    (r_state == FLUSH),
        .o_count     (w_timer_count),
        .o_zero      (w_timer_zero)
    );

    always_comb begin
        w_next_state = r_state;
        s_ready      = 1'b0;
        cpu_hold     = 1'b1;
        pc_reset     = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                pc_reset = 1'b1;
                if (start) w_next_state = LOAD;
            end
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (w_end_load) w_next_state = FLUSH;
            end
            FLUSH: begin
                pc_reset = 1'b1;
                busy     = 1'b1;
                if (w_timer_zero) w_next_state = RUN;
            end
            RUN: begin
                cpu_hold = 1'b0;
                if (start) w_next_state = LOAD;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_imem_we      <= 1'b0;
            r_imem_addr    <= BASE_ADDR;
            r_imem_wdata   <= '0;
            r_word_count   <= '0;
            r_err_overflow <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_done    <= (r_state == FLUSH) && w_timer_zero;
            r_imem_we <= w_beat;
            if (w_start_load) begin
                r_word_count   <= '0;
                r_err_overflow <= 1'b0;
            end
            // Address uses the pre-increment count, so the first word lands at BASE_ADDR.
            if (w_beat) begin
                r_imem_addr  <= BASE_ADDR + (32'(r_word_count) * 32'(WORD_BYTES));
                r_imem_wdata <= s_data;
                r_word_count <= w_wc_next;
                if (w_full && !s_last) r_err_overflow <= 1'b1;
            end
        end
    end

    assign imem_we      = r_imem_we;
    assign imem_addr    = r_imem_addr;
    assign imem_wdata   = r_imem_wdata;
    assign word_count   = r_word_count;
    assign err_overflow = r_err_overflow;
    assign done         = r_done;

endmodule
